// File: rtl/sev_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// sev_seg_scan_driver
//   Feeds a 4-digit common-anode seven-segment display. A 14-bit binary amount
//   is captured on a load strobe and converted to four BCD digits with a
//   sequential shift-add-3 (double-dabble) engine. The committed digits are
//   time-multiplexed onto one shared BCD bus with active-low anode enables
//   and optional leading-zero blanking.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit stays lit (2 .. 2**CNT_W)
//   CNT_W       : refresh counter width, 2**CNT_W >= REFRESH_DIV
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   single-cycle strobe: capture value and start conversion
//   value    in   [13:0] binary amount to display
//   blank_lz in   1 = suppress leading zeros on digits 3..1
//   busy     out  conversion in progress
//   done     out  one-cycle pulse when new digits are committed
//   ovf      out  latched 1 if the last loaded value exceeded 9999
//   LED_BCD  out  [3:0] BCD digit of the currently selected position
//   anode_n  out  [3:0] active-low digit enables, bit 0 = ones digit
// ---------------------------------------------------------------------------
module sev_seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  input  logic        blank_lz,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  LED_BCD,
  output logic [3:0]  anode_n
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t       r_state;
  state_t       w_state_nxt;

  logic [13:0]  r_bin;      // binary shift register, MSB shifted out first
  logic [13:0]  r_val;      // captured value, kept for the range check
  logic [15:0]  r_acc;      // BCD accumulator
  logic [3:0]   r_bitcnt;   // remaining shift steps
  logic [15:0]  r_dig;      // committed display digits, nibble k = digit k
  logic         r_busy;
  logic         r_done;
  logic         r_ovf;

  logic [CNT_W-1:0] r_refresh;
  logic [1:0]       r_sel;

  logic         w_latch;
  logic         w_shift;
  logic         w_commit;
  logic         w_ovf;
  logic [15:0]  w_acc_adj;
  logic [3:0]   w_zero;
  logic         w_blank;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [15:0] dabble_adj(input logic [15:0] acc);
    logic [15:0] res;
    res = 16'd0;
    for (int k = 0; k < 4; k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        res[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end else begin
        res[4*k +: 4] = acc[4*k +: 4];
      end
    end
    return res;
  endfunction

  // Converter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Converter next-state logic; load outside IDLE is deliberately ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == 4'd1) begin
          w_state_nxt = S_COMMIT;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Converter control decode.
  always_comb begin
    w_latch  = 1'b0;
    w_shift  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE:   w_latch  = load;
      S_SHIFT:  w_shift  = 1'b1;
      S_COMMIT: w_commit = 1'b1;
      default: begin
        w_latch  = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
      end
    endcase
  end

  assign w_acc_adj = dabble_adj(r_acc);
  assign w_ovf     = (r_val > 14'd9999);

  // Conversion datapath; display digits only change in the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= 14'd0;
      r_val    <= 14'd0;
      r_acc    <= 16'd0;
      r_bitcnt <= 4'd0;
      r_dig    <= 16'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_latch) begin
        r_bin    <= value;
        r_val    <= value;
        r_acc    <= 16'd0;
        r_bitcnt <= 4'd14;
        r_busy   <= 1'b1;
      end else if (w_shift) begin
        {r_acc, r_bin} <= {w_acc_adj[14:0], r_bin, 1'b0};
        r_bitcnt       <= r_bitcnt - 4'd1;
      end else if (w_commit) begin
        r_busy <= 1'b0;
        r_ovf  <= w_ovf;
        r_dig  <= w_ovf ? 16'hEEEE : r_acc;
      end
    end
  end

  // Refresh counter and digit select, free running after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_sel     <= 2'd0;
    end else if (r_refresh == REFRESH_LAST) begin
      r_refresh <= '0;
      r_sel     <= r_sel + 2'd1;
    end else begin
      r_refresh <= r_refresh + CNT_W'(1);
    end
  end

  // Zero flags of the committed digits, used for leading-zero blanking.
  always_comb begin
    w_zero = 4'd0;
    for (int k = 0; k < 4; k++) begin
      w_zero[k] = (r_dig[4*k +: 4] == 4'd0);
    end
  end

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    w_blank = 1'b0;
    if (blank_lz && !r_ovf) begin
      case (r_sel)
        2'd0:    w_blank = 1'b0;
        2'd1:    w_blank = w_zero[1] & w_zero[2] & w_zero[3];
        2'd2:    w_blank = w_zero[2] & w_zero[3];
        2'd3:    w_blank = w_zero[3];
        default: w_blank = 1'b0;
      endcase
    end else begin
      w_blank = 1'b0;
    end
  end

  // Scan outputs are decoded from registered state so the decoder sees
  // the new digits in the same cycle that done pulses.
  always_comb begin
    LED_BCD = r_dig[4*r_sel +: 4];
    if (w_blank) begin
      anode_n = 4'b1111;
    end else begin
      anode_n = ~(4'b0001 << r_sel);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;

endmodule

// File: doc/sev_seg_scan_driver.md
Name: sev_seg_scan_driver

Overview:
- Upstream feeder for the ATM's 4-digit common-anode seven-segment display.
- Accepts a 14-bit binary amount (0..9999) on a load strobe. Converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto one shared 4-bit BCD bus for the downstream segment decoder, driving active-low digit anodes, with optional leading-zero blanking.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit before advancing (1 kHz per digit at 100 MHz); legal range 2..2^CNT_W.
- CNT_W, 17, width of refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; capture value and start conversion.
- value  input  14  binary amount to display.
- blank_lz  input  1  1 = suppress leading zeros on digits 3..1.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when new digits are committed to the display.
- ovf  output  1  latched 1 if last loaded value > 9999.
- LED_BCD  output  4  BCD digit for the currently selected position; goes to the segment decoder.
- anode_n  output  4  active-low digit enables; bit 0 is the rightmost (ones) digit.

Behaviour:
- Reset (async assert, sync-safe release):
  - busy=0, done=0, ovf=0.
  - Digit registers = 0; refresh counter = 0; digit_sel = 0.
  - LED_BCD=4'h0, anode_n=4'b1110.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: when load=1, latch value into shift register, clear BCD accumulator, set bit counter=14, go to SHIFT. busy rises the cycle after load is sampled.
  - SHIFT: one bit per cycle. For each BCD nibble >= 5, add 3, then shift left 1 pulling in the next binary MSB. Exactly 14 SHIFT cycles, then go to COMMIT.
  - COMMIT: one cycle.
    - Copy accumulator to display digit registers.
    - Set ovf = (latched value > 9999).
    - If ovf, force all four digits to 4'hE; the decoder shows "EEEE".
    - Pulse done=1 and return to IDLE. busy=0 in the same cycle as done.
  - Latency: load sampled at edge N; done high in the cycle after edge N+15; new digits visible on LED_BCD from that cycle.
  - load while busy is ignored: no restart, no queueing.
  - Display holds the previous digits for the whole conversion, so no flicker of partial results.
- Scanner (runs independently of the FSM, always active after reset):
  - Refresh counter counts 0..REFRESH_DIV-1. On wrap, digit_sel increments modulo 4 (0→1→2→3→0).
  - LED_BCD = digit[digit_sel], combinational from registered state.
  - anode_n = all ones except bit digit_sel low, unless that digit is blanked.
  - Blanking:
    - Digit k (k=1..3) is blanked when blank_lz=1, ovf=0, and digits k..3 are all zero. A blanked digit has anode_n=4'b1111 during its slot.
    - Digit 0 is never blanked; value 0 displays "0".
    - Blanking is evaluated on the committed digits only.
- Arithmetic:
  - BCD accumulator is 16 bits. Value 9999 converts exactly.
  - Values 10000..16383 set ovf and never wrap into digits.
- Reset mid-conversion aborts immediately: FSM to IDLE, digits 0, done never pulses.

Test Plan:
- Reset then release with blank_lz=0 and REFRESH_DIV=4 → anode_n cycles 1110,1101,1011,0111 every 4 clocks, LED_BCD=0 throughout; busy=0, done=0.
- load with value=1234 → busy for 15 cycles, done one cycle after edge N+15; LED_BCD shows 4,3,2,1 in slots 0..3; ovf=0.
- value=9999 then value=0 → digits 9,9,9,9 then 0,0,0,0. With blank_lz=1, the second value shows only slot 0 lit (anode_n=1110); slots 1..3 show anode_n=1111.
- value=10000 → ovf=1, LED_BCD=4'hE in all slots, no blanking even with blank_lz=1. A following load of 42 clears ovf.
- load 500, then re-pulse load with 777 at cycle N+5 → second load ignored; display 0500 (blank_lz=1: slot 3 blanked); exactly one done pulse.
- Assert rst_n low at cycle N+7 of a conversion of 8888 → immediate reset values, no done pulse; after release the display reads 0 and a fresh load of 8888 completes normally.
